// File: rtl/voting_pkg.sv
// Shared definitions for the voting session controller: state encoding and verdict bit positions.
package voting_pkg;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] OPEN   = 2'd1;
    localparam logic [1:0] TALLY  = 2'd2;
    localparam logic [1:0] RESULT = 2'd3;

    typedef enum logic [1:0] {
        StIdle   = IDLE,
        StOpen   = OPEN,
        StTally  = TALLY,
        StResult = RESULT
    } state_e;

    localparam int unsigned RES_FAIL = 0;
    localparam int unsigned RES_TIE  = 1;
    localparam int unsigned RES_PASS = 2;

endpackage

// File: rtl/voting_tally.sv
// Combinational ballot counter: yes/no popcounts over accepted ballots and a one-hot verdict.
module voting_tally
    import voting_pkg::*;
#(
    parameter int unsigned N_VOTERS = 4,
    parameter int unsigned CW       = $clog2(N_VOTERS + 1)
) (
    input  logic [N_VOTERS-1:0] ballot,
    input  logic [N_VOTERS-1:0] voted,
    output logic [CW-1:0]       yes_cnt,
    output logic [CW-1:0]       no_cnt,
    output logic [2:0]          verdict
);

    always_comb begin
        yes_cnt = '0;
        no_cnt  = '0;
        for (int i = 0; i < int'(N_VOTERS); i++) begin
            yes_cnt = yes_cnt + CW'(ballot[i] & voted[i]);
            no_cnt  = no_cnt + CW'(~ballot[i] & voted[i]);
        end
        verdict           = '0;
        verdict[RES_PASS] = (yes_cnt > no_cnt);
        verdict[RES_FAIL] = (no_cnt > yes_cnt);
        verdict[RES_TIE]  = (yes_cnt == no_cnt);
    end

endmodule

// File: rtl/voting_session_ctrl.sv
// One-ballot-at-a-time session sequencer: opens on start, locks one vote per voter,
// closes on full turnout or timeout, then holds a registered verdict for a fixed window.
module voting_session_ctrl
    import voting_pkg::*;
#(
    parameter int unsigned N_VOTERS    = 4,
    parameter int unsigned TIMEOUT     = 16,
    parameter int unsigned RESULT_HOLD = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [N_VOTERS-1:0]             yes,
    input  logic [N_VOTERS-1:0]             no,
    output logic                            busy,
    output logic [N_VOTERS-1:0]             voted,
    output logic [$clog2(N_VOTERS+1)-1:0]   yes_cnt,
    output logic [$clog2(N_VOTERS+1)-1:0]   no_cnt,
    output logic [2:0]                      result,
    output logic                            result_valid
);

    localparam int unsigned CW = $clog2(N_VOTERS + 1);
    localparam int unsigned TW = $clog2(TIMEOUT);
    localparam int unsigned HW = $clog2(RESULT_HOLD + 1);

    state_e              state_q, state_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [HW-1:0]       hold_q, hold_d;
    logic                tally_ph_q, tally_ph_d;
    logic [N_VOTERS-1:0] voted_q, voted_d;
    logic [N_VOTERS-1:0] ballot_q, ballot_d;
    logic [CW-1:0]       yes_cnt_q, yes_cnt_d;
    logic [CW-1:0]       no_cnt_q, no_cnt_d;
    logic [2:0]          result_q, result_d;

    logic [N_VOTERS-1:0] accept;
    logic [CW-1:0]       tally_yes, tally_no;
    logic [2:0]          tally_verdict;

    voting_tally #(
        .N_VOTERS (N_VOTERS),
        .CW       (CW)
    ) u_tally (
        .ballot  (ballot_q),
        .voted   (voted_q),
        .yes_cnt (tally_yes),
        .no_cnt  (tally_no),
        .verdict (tally_verdict)
    );

    // A ballot is taken only from an unlocked voter pressing exactly one button.
    assign accept = ~voted_q & (yes ^ no);

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        hold_d     = hold_q;
        tally_ph_d = tally_ph_q;
        voted_d    = voted_q;
        ballot_d   = ballot_q;
        yes_cnt_d  = yes_cnt_q;
        no_cnt_d   = no_cnt_q;
        result_d   = result_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d  = StOpen;
                    voted_d  = '0;
                    ballot_d = '0;
                    timer_d  = TW'(TIMEOUT - 1);
                end
            end
            StOpen: begin
                voted_d  = voted_q | accept;
                ballot_d = (ballot_q & ~accept) | (accept & yes);
                timer_d  = timer_q - TW'(1);
                if ((&voted_d) || (timer_q == '0)) begin
                    state_d    = StTally;
                    tally_ph_d = 1'b0;
                end
            end
            StTally: begin
                // Two edges in TALLY put the verdict two cycles after the closing edge.
                if (!tally_ph_q) begin
                    tally_ph_d = 1'b1;
                end else begin
                    state_d   = StResult;
                    yes_cnt_d = tally_yes;
                    no_cnt_d  = tally_no;
                    result_d  = tally_verdict;
                    hold_d    = HW'(RESULT_HOLD - 1);
                end
            end
            StResult: begin
                if (hold_q == '0) begin
                    state_d   = StIdle;
                    yes_cnt_d = '0;
                    no_cnt_d  = '0;
                    result_d  = '0;
                end else begin
                    hold_d = hold_q - HW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            timer_q    <= '0;
            hold_q     <= '0;
            tally_ph_q <= 1'b0;
            voted_q    <= '0;
            ballot_q   <= '0;
            yes_cnt_q  <= '0;
            no_cnt_q   <= '0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            hold_q     <= hold_d;
            tally_ph_q <= tally_ph_d;
            voted_q    <= voted_d;
            ballot_q   <= ballot_d;
            yes_cnt_q  <= yes_cnt_d;
            no_cnt_q   <= no_cnt_d;
            result_q   <= result_d;
        end
    end

    assign busy         = (state_q != StIdle);
    assign voted        = voted_q;
    assign yes_cnt      = yes_cnt_q;
    assign no_cnt       = no_cnt_q;
    assign result       = result_q;
    assign result_valid = (state_q == StResult);

endmodule

// File: tb/tb_voting_session_ctrl.sv
// Self-checking bench for voting_session_ctrl: directed plan scenarios plus randomized sessions
// checked against a ballot-level reference model.
module tb_voting_session_ctrl;

    localparam int N  = 4;
    localparam int T  = 16;
    localparam int H  = 8;
    localparam int CW = $clog2(N + 1);
    localparam int SL = 40;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [N-1:0]  yes;
    logic [N-1:0]  no;
    logic          busy;
    logic [N-1:0]  voted;
    logic [CW-1:0] yes_cnt;
    logic [CW-1:0] no_cnt;
    logic [2:0]    result;
    logic          result_valid;

    voting_session_ctrl #(
        .N_VOTERS    (N),
        .TIMEOUT     (T),
        .RESULT_HOLD (H)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .yes          (yes),
        .no           (no),
        .busy         (busy),
        .voted        (voted),
        .yes_cnt      (yes_cnt),
        .no_cnt       (no_cnt),
        .result       (result),
        .result_valid (result_valid)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Per-cycle stimulus; index k is sampled on the k-th edge after the start edge.
    logic [N-1:0] s_yes [SL];
    logic [N-1:0] s_no  [SL];
    logic         s_start [SL];

    // Observations from the last session.
    int            o_rise, o_len;
    logic          o_busy0, o_unstable;
    logic [2:0]    o_res, o_res_after;
    logic [CW-1:0] o_yc, o_nc, o_yc_after, o_nc_after;
    logic [N-1:0]  o_voted, o_voted_after;
    logic          o_busy_after;

    // Model expectations.
    int           e_rise, e_yc, e_nc;
    logic [2:0]   e_res;
    logic [N-1:0] e_voted;

    task automatic clear_stim;
        for (int k = 0; k < SL; k++) begin
            s_yes[k] = '0;
            s_no[k] = '0;
            s_start[k] = 1'b0;
        end
    endtask

    // Reference: first single-button press per voter wins; session closes when all have voted
    // or after T sampled cycles; verdict appears two edges after the close.
    task automatic model;
        logic [N-1:0] v, b;
        int c;
        v = '0;
        b = '0;
        c = T;
        for (int k = 1; k <= T; k++) begin
            for (int i = 0; i < N; i++)
                if (!v[i] && (s_yes[k][i] != s_no[k][i])) begin
                    v[i] = 1'b1;
                    b[i] = s_yes[k][i];
                end
            if (v == {N{1'b1}}) begin
                c = k;
                break;
            end
        end
        e_yc = 0;
        e_nc = 0;
        for (int i = 0; i < N; i++) begin
            if (v[i] && b[i]) e_yc++;
            if (v[i] && !b[i]) e_nc++;
        end
        e_voted = v;
        e_rise = c + 2;
        e_res = (e_yc > e_nc) ? 3'b100 : (e_yc < e_nc) ? 3'b001 : 3'b010;
    endtask

    task automatic run_session;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        o_busy0 = busy;
        o_rise = 0;
        o_len = 0;
        o_unstable = 1'b0;
        for (int k = 1; k < SL; k++) begin
            yes = s_yes[k];
            no = s_no[k];
            start = s_start[k];
            @(posedge clk); #1;
            if (result_valid) begin
                if (o_len == 0) begin
                    o_rise = k;
                    o_res = result;
                    o_yc = yes_cnt;
                    o_nc = no_cnt;
                    o_voted = voted;
                end else if (result !== o_res || yes_cnt !== o_yc || no_cnt !== o_nc ||
                             voted !== o_voted) begin
                    o_unstable = 1'b1;
                end
                o_len++;
            end else if (o_len != 0) begin
                break;
            end
        end
        yes = '0;
        no = '0;
        start = 1'b0;
        o_res_after = result;
        o_yc_after = yes_cnt;
        o_nc_after = no_cnt;
        o_busy_after = busy;
        o_voted_after = voted;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start = 1'b0;
        yes = '0;
        no = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, voted, yes_cnt, no_cnt, result, result_valid} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got busy=%b voted=%b yc=%0d nc=%0d res=%b rv=%b want 0",
                     busy, voted, yes_cnt, no_cnt, result, result_valid);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_all_yes;
        clear_stim();
        s_yes[1] = 4'b1111;
        model();
        run_session();
        n_cmp++;
        if (o_busy0 !== 1'b1) begin
            n_bad++;
            $display("FAIL all_yes_busy: got %b want 1", o_busy0);
        end
        n_cmp++;
        if (o_voted !== 4'b1111) begin
            n_bad++;
            $display("FAIL all_yes_voted: got %b want 1111", o_voted);
        end
        n_cmp++;
        if (o_rise != 3 || o_res !== 3'b100) begin
            n_bad++;
            $display("FAIL all_yes_verdict: got rise=%0d res=%b want rise=3 res=100", o_rise, o_res);
        end
        n_cmp++;
        if (o_yc !== CW'(4) || o_nc !== CW'(0)) begin
            n_bad++;
            $display("FAIL all_yes_counts: got %0d/%0d want 4/0", o_yc, o_nc);
        end
        n_cmp++;
        if (o_len != H || o_unstable) begin
            n_bad++;
            $display("FAIL all_yes_hold: got len=%0d unstable=%b want len=%0d stable", o_len,
                     o_unstable, H);
        end
        n_cmp++;
        if (o_res_after !== 3'b000 || o_yc_after !== '0 || o_nc_after !== '0 || o_busy_after) begin
            n_bad++;
            $display("FAIL all_yes_after: got res=%b yc=%0d nc=%0d busy=%b want all 0",
                     o_res_after, o_yc_after, o_nc_after, o_busy_after);
        end
        n_cmp++;
        if (o_voted_after !== 4'b1111) begin
            n_bad++;
            $display("FAIL all_yes_voted_hold: got %b want 1111", o_voted_after);
        end
    endtask

    task automatic test_split_lock;
        clear_stim();
        s_yes[1] = 4'b0001;
        s_no[2]  = 4'b0001;
        s_yes[3] = 4'b0010;
        s_no[4]  = 4'b0100;
        s_no[5]  = 4'b1001;
        model();
        run_session();
        n_cmp++;
        if (o_res !== 3'b010 || o_yc !== CW'(2) || o_nc !== CW'(2)) begin
            n_bad++;
            $display("FAIL split_lock: got res=%b %0d/%0d want res=010 2/2", o_res, o_yc, o_nc);
        end
        n_cmp++;
        if (o_rise != e_rise) begin
            n_bad++;
            $display("FAIL split_lock_latency: got %0d want %0d", o_rise, e_rise);
        end
    endtask

    task automatic test_timeout;
        clear_stim();
        s_no[5] = 4'b1000;
        model();
        run_session();
        n_cmp++;
        if (o_rise != T + 2 || o_voted !== 4'b1000) begin
            n_bad++;
            $display("FAIL timeout_close: got rise=%0d voted=%b want rise=%0d voted=1000", o_rise,
                     o_voted, T + 2);
        end
        n_cmp++;
        if (o_res !== 3'b001 || o_yc !== CW'(0) || o_nc !== CW'(1)) begin
            n_bad++;
            $display("FAIL timeout_verdict: got res=%b %0d/%0d want 001 0/1", o_res, o_yc, o_nc);
        end
    endtask

    task automatic test_no_votes;
        clear_stim();
        model();
        run_session();
        n_cmp++;
        if (o_rise != 18 || o_res !== 3'b010 || o_yc !== '0 || o_nc !== '0 || o_voted !== '0) begin
            n_bad++;
            $display("FAIL no_votes: got rise=%0d res=%b %0d/%0d voted=%b want 18 010 0/0 0000",
                     o_rise, o_res, o_yc, o_nc, o_voted);
        end
    endtask

    task automatic test_illegal_start;
        clear_stim();
        for (int k = 1; k <= 5; k++) begin
            s_yes[k] = 4'b0010;
            s_no[k]  = 4'b0010;
        end
        s_yes[2] = 4'b0011;
        s_start[3] = 1'b1;
        s_no[7] = 4'b0010;
        s_yes[8] = 4'b0100;
        s_no[9] = 4'b1000;
        model();
        run_session();
        n_cmp++;
        if (o_rise != 11 || o_rise != e_rise) begin
            n_bad++;
            $display("FAIL illegal_start_rise: got %0d want %0d", o_rise, e_rise);
        end
        n_cmp++;
        if (o_voted !== 4'b1111 || o_yc !== CW'(2) || o_nc !== CW'(2) || o_res !== 3'b010) begin
            n_bad++;
            $display("FAIL illegal_start_tally: got voted=%b %0d/%0d res=%b want 1111 2/2 010",
                     o_voted, o_yc, o_nc, o_res);
        end
    endtask

    task automatic test_reset_mid;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        yes = 4'b0001;
        no = 4'b0100;
        @(posedge clk); #1;
        yes = '0;
        no = '0;
        n_cmp++;
        if (voted !== 4'b0101) begin
            n_bad++;
            $display("FAIL reset_mid_pre: got voted=%b want 0101", voted);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({busy, voted, yes_cnt, no_cnt, result, result_valid} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid_clear: got busy=%b voted=%b rv=%b want 0", busy, voted,
                     result_valid);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        clear_stim();
        s_no[2] = 4'b1111;
        model();
        run_session();
        n_cmp++;
        if (o_rise != 4 || o_res !== 3'b001 || o_yc !== '0 || o_nc !== CW'(4)) begin
            n_bad++;
            $display("FAIL reset_mid_clean: got rise=%0d res=%b %0d/%0d want 4 001 0/4", o_rise,
                     o_res, o_yc, o_nc);
        end
    endtask

    task automatic test_random;
        int dens;
        for (int s = 0; s < 25; s++) begin
            clear_stim();
            dens = $urandom_range(0, 4);
            for (int k = 1; k < SL; k++) begin
                for (int i = 0; i < N; i++) begin
                    s_yes[k][i] = ($urandom_range(0, 19) < dens);
                    s_no[k][i]  = ($urandom_range(0, 19) < dens);
                end
                s_start[k] = ($urandom_range(0, 7) == 0);
            end
            model();
            run_session();
            n_cmp++;
            if (o_rise != e_rise || o_voted !== e_voted) begin
                n_bad++;
                $display("FAIL rand%0d_close: got rise=%0d voted=%b want rise=%0d voted=%b", s,
                         o_rise, o_voted, e_rise, e_voted);
            end
            n_cmp++;
            if (o_res !== e_res || o_yc !== CW'(e_yc) || o_nc !== CW'(e_nc)) begin
                n_bad++;
                $display("FAIL rand%0d_tally: got res=%b %0d/%0d want res=%b %0d/%0d", s, o_res,
                         o_yc, o_nc, e_res, e_yc, e_nc);
            end
            n_cmp++;
            if (o_len != H || o_unstable || o_busy_after || o_res_after !== '0 ||
                o_voted_after !== e_voted) begin
                n_bad++;
                $display("FAIL rand%0d_hold: got len=%0d unstable=%b busy=%b res=%b voted=%b", s,
                         o_len, o_unstable, o_busy_after, o_res_after, o_voted_after);
            end
        end
    endtask

    initial begin
        test_reset();
        test_all_yes();
        test_split_lock();
        test_timeout();
        test_no_votes();
        test_illegal_start();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
